wvb_reader_arb: RTL and testbench

WVB_READER_ARB -- requirements
Module: wvb_reader_arb

---
 rtl/wvb_reader_arb.sv | 149 ++++++++++++++
 tb/tb_wvb_reader_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wvb_reader_arb.sv
// Round-robin arbiter that hands waveform-buffer events to a DPRAM readout controller.
// Optional completed-event counter: define WVB_READER_EVT_CNT_EN to add the evt_cnt port.
module wvb_reader_arb #(
    parameter int N_CHANNELS = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dpram_mode,
    input  logic [N_CHANNELS-1:0] wvb_not_empty,
    output logic                  rd_req,
    output logic [7:0]            rd_idx,
    output logic                  rd_dpram_mode,
    input  logic                  rd_ack,
    input  logic                  rd_ctrl_more,
    input  logic [15:0]           rd_dpram_len,
    output logic                  dpram_ready,
    output logic [15:0]           dpram_len,
    input  logic                  dpram_done,
`ifdef WVB_READER_EVT_CNT_EN
    output logic [31:0]           evt_cnt,
`endif
    output logic [1:0]            state_dbg
);

    // Handshake: rd_req rises with rd_idx/rd_dpram_mode stable and stays high until the
    // host releases the DPRAM; the controller raises rd_ack (with rd_ctrl_more and
    // rd_dpram_len valid) and holds it until it sees rd_req low. A new rd_req is only
    // issued after rd_ack has been seen low.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_HOST_WAIT = 2'd2,
        S_REL       = 2'd3
    } state_t;

    state_t     state;
    logic       more_reg;
    logic [7:0] last_idx;
    logic [1:0] rst_sync;
    logic       rst_core_n;

    // Reset asserts immediately but releases the core only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync[1];
    assign state_dbg  = state;

    logic       hi_found;
    logic [7:0] hi_idx;
    logic       lo_found;
    logic [7:0] lo_idx;
    logic [7:0] pick_idx;

    // Lowest set channel above last_idx wins; otherwise wrap to the lowest set channel.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (wvb_not_empty[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 8'(i);
            end
            if (wvb_not_empty[i] && !hi_found && (8'(i) > last_idx)) begin
                hi_found = 1'b1;
                hi_idx   = 8'(i);
            end
        end
    end

    assign pick_idx = hi_found ? hi_idx : lo_idx;

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state         <= S_IDLE;
            rd_req        <= 1'b0;
            rd_idx        <= '0;
            rd_dpram_mode <= 1'b0;
            dpram_ready   <= 1'b0;
            dpram_len     <= '0;
            more_reg      <= 1'b0;
            last_idx      <= 8'(N_CHANNELS - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && lo_found) begin
                        rd_req        <= 1'b1;
                        rd_idx        <= pick_idx;
                        rd_dpram_mode <= dpram_mode;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rd_ack) begin
                        dpram_len   <= rd_dpram_len;
                        more_reg    <= rd_ctrl_more;
                        dpram_ready <= 1'b1;
                        state       <= S_HOST_WAIT;
                    end
                end
                S_HOST_WAIT: begin
                    if (dpram_done) begin
                        rd_req      <= 1'b0;
                        dpram_ready <= 1'b0;
                        dpram_len   <= '0;
                        state       <= S_REL;
                    end
                end
                S_REL: begin
                    // Continuations keep the channel; only a finished event moves the pointer.
                    if (!rd_ack) begin
                        if (more_reg) begin
                            rd_req <= 1'b1;
                            state  <= S_REQ;
                        end else begin
                            last_idx <= rd_idx;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    rd_req      <= 1'b0;
                    dpram_ready <= 1'b0;
                    dpram_len   <= '0;
                end
            endcase
        end
    end

`ifdef WVB_READER_EVT_CNT_EN
    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            evt_cnt <= '0;
        end else if (state == S_REL && !rd_ack && !more_reg) begin
            evt_cnt <= evt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wvb_reader_arb.sv
// Bench for wvb_reader_arb: directed scenarios plus randomized events against a
// round-robin pick model and an expected-selection queue.
module tb_wvb_reader_arb;
    localparam int N  = 24;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              dpram_mode;
    logic [N-1:0]      wvb_not_empty;
    logic              rd_req;
    logic [7:0]        rd_idx;
    logic              rd_dpram_mode;
    logic              rd_ack;
    logic              rd_ctrl_more;
    logic [15:0]       rd_dpram_len;
    logic              dpram_ready;
    logic [15:0]       dpram_len;
    logic              dpram_done;
`ifdef WVB_READER_EVT_CNT_EN
    logic [31:0]       evt_cnt;
`endif
    logic [1:0]        state_dbg;

    int                n_chk  = 0;
    int                n_pass = 0;
    logic [8:0]        exp_q[$];   // {mode, channel} of each expected selection
    int                last_m = N - 1;
    int                done_m = 0;
    logic              in_reset = 1'b1;
    logic [7:0]        last_served;
    logic [7:0]        ord[4];
    logic              prev_req = 1'b0;
    logic              prev_ack = 1'b0;
    logic              prev_ready = 1'b0;
    logic              prev_mode = 1'b0;
    logic [7:0]        prev_idx = '0;

    always #5 clk = ~clk;

    wvb_reader_arb #(.N_CHANNELS(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .dpram_mode    (dpram_mode),
        .wvb_not_empty (wvb_not_empty),
        .rd_req        (rd_req),
        .rd_idx        (rd_idx),
        .rd_dpram_mode (rd_dpram_mode),
        .rd_ack        (rd_ack),
        .rd_ctrl_more  (rd_ctrl_more),
        .rd_dpram_len  (rd_dpram_len),
        .dpram_ready   (dpram_ready),
        .dpram_len     (dpram_len),
        .dpram_done    (dpram_done),
`ifdef WVB_READER_EVT_CNT_EN
        .evt_cnt       (evt_cnt),
`endif
        .state_dbg     (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round robin: first set flag at (last+1), (last+2), ... modulo N.
    function automatic logic [7:0] pick(input logic [N-1:0] f, input int last);
        logic [IW-1:0] c;
        for (int k = 1; k <= N; k++) begin
            c = IW'((last + k) % N);
            if (f[c]) return 8'(c);
        end
        return 8'hFF;
    endfunction

    task automatic wait_req(input int max_cyc);
        int n;
        n = 0;
        while (!rd_req && n < max_cyc) begin
            tick();
            n++;
        end
        check("req_seen", 32'(rd_req), 32'd1);
    endtask

    // One whole event; nbufs==0 means random length when the selected mode allows spanning.
    task automatic serve_event(input int nbufs, input int ack_dly, input int len_fix,
                               input logic stray, input logic [N-1:0] nxt_flags,
                               input logic nxt_mode, input logic nxt_en);
        logic [8:0]  e;
        logic [15:0] len;
        int          nb;
        wait_req(20);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
        last_served = rd_idx;
        check("sel_idx", 32'(rd_idx), 32'(e[7:0]));
        check("sel_mode", 32'(rd_dpram_mode), 32'(e[8]));
`ifdef WVB_READER_EVT_CNT_EN
        check("evt_cnt_at_sel", evt_cnt, 32'(done_m));
`endif
        nb = (nbufs > 0) ? nbufs : (e[8] ? $urandom_range(1, 3) : 1);
        dpram_mode    = ~e[8];
        wvb_not_empty = N'($urandom);
        en            = 1'($urandom_range(0, 1));
        for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
                check("cont_req", 32'(rd_req), 32'd1);
                check("cont_idx", 32'(rd_idx), 32'(e[7:0]));
                check("cont_mode", 32'(rd_dpram_mode), 32'(e[8]));
            end
            repeat ((ack_dly >= 0) ? ack_dly : $urandom_range(0, 4)) tick();
            if (stray) begin
                dpram_done = 1'b1;
                tick();
                dpram_done = 1'b0;
                check("stray_done_ready", 32'(dpram_ready), 32'd0);
                check("stray_done_req", 32'(rd_req), 32'd1);
            end
            len          = (len_fix >= 0) ? 16'(len_fix) : 16'($urandom);
            rd_ack       = 1'b1;
            rd_ctrl_more = (b < nb - 1);
            rd_dpram_len = len;
            tick();
            rd_ctrl_more = 1'($urandom);
            rd_dpram_len = 16'($urandom);
            check("ready_set", 32'(dpram_ready), 32'd1);
            check("len_cap", 32'(dpram_len), 32'(len));
            check("req_held", 32'(rd_req), 32'd1);
            if (b == nb - 1) begin
                wvb_not_empty = nxt_flags;
                dpram_mode    = nxt_mode;
                en            = nxt_en;
                last_m        = int'(e[7:0]);
                if (nxt_en && nxt_flags != '0) exp_q.push_back({nxt_mode, pick(nxt_flags, last_m)});
            end
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("ready_hold", 32'(dpram_ready), 32'd1);
                check("len_hold", 32'(dpram_len), 32'(len));
            end
            dpram_done = 1'b1;
            tick();
            dpram_done = 1'b0;
            check("rel_req", 32'(rd_req), 32'd0);
            check("rel_ready", 32'(dpram_ready), 32'd0);
            check("rel_len", 32'(dpram_len), 32'd0);
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("req_waits_ack_low", 32'(rd_req), 32'd0);
            end
            rd_ack = 1'b0;
            tick();
        end
        check("idle_gap", 32'(rd_req), 32'd0);
        done_m++;
`ifdef WVB_READER_EVT_CNT_EN
        check("evt_cnt_done", evt_cnt, 32'(done_m));
`endif
        if (nxt_en && nxt_flags != '0) begin
            tick();
            check("sel_latency", 32'(rd_req), 32'd1);
        end
    endtask

    // Cycle-by-cycle protocol rules, sampled on the falling edge.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (!dpram_ready) check("len_zero_not_ready", 32'(dpram_len), 32'd0);
            if (!prev_req && rd_req) check("rise_after_ack_low", 32'(prev_ack), 32'd0);
            if (prev_req && !rd_req) check("fall_with_release", 32'(prev_ready & ~dpram_ready), 32'd1);
            if (prev_req && rd_req) begin
                check("idx_stable", 32'(rd_idx), 32'(prev_idx));
                check("mode_stable", 32'(rd_dpram_mode), 32'(prev_mode));
            end
        end
        prev_req   = rd_req;
        prev_ack   = rd_ack;
        prev_ready = dpram_ready;
        prev_idx   = rd_idx;
        prev_mode  = rd_dpram_mode;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] nf;
        logic         nm;
        rst_n = 1'b0; en = 1'b0; dpram_mode = 1'b0; wvb_not_empty = '0;
        rd_ack = 1'b0; rd_ctrl_more = 1'b0; rd_dpram_len = '0; dpram_done = 1'b0;
        repeat (3) tick();
        check("rst_req", 32'(rd_req), 32'd0);
        check("rst_idx", 32'(rd_idx), 32'd0);
        check("rst_ready", 32'(dpram_ready), 32'd0);
        check("rst_len", 32'(dpram_len), 32'd0);
        rst_n = 1'b1;
        in_reset = 1'b0;

        // Single event on channel 2.
        wvb_not_empty = 24'h000004;
        en = 1'b1;
        check("pin_first_pick", 32'(pick(24'h000004, last_m)), 32'd2);
        exp_q.push_back({1'b0, pick(24'h000004, last_m)});
        serve_event(1, 5, 16'h0040, 1'b0, 24'h000010, 1'b1, 1'b1);
        check("single_ch", 32'(last_served), 32'd2);
`ifdef WVB_READER_EVT_CNT_EN
        check("single_evt_cnt", evt_cnt, 32'd1);
`endif

        // Reset while the host holds the DPRAM of channel 4.
        wait_req(20);
        void'(exp_q.pop_front());
        check("rst_pre_idx", 32'(rd_idx), 32'd4);
        rd_ack = 1'b1; rd_dpram_len = 16'hBEEF; rd_ctrl_more = 1'b1;
        tick();
        check("rst_pre_ready", 32'(dpram_ready), 32'd1);
        wvb_not_empty = 24'h800001;
        dpram_mode = 1'b0;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(rd_req), 32'd0);
        check("mid_rst_idx", 32'(rd_idx), 32'd0);
        check("mid_rst_mode", 32'(rd_dpram_mode), 32'd0);
        check("mid_rst_ready", 32'(dpram_ready), 32'd0);
        check("mid_rst_len", 32'(dpram_len), 32'd0);
`ifdef WVB_READER_EVT_CNT_EN
        check("mid_rst_evt_cnt", evt_cnt, 32'd0);
`endif
        rd_ack = 1'b0; rd_ctrl_more = 1'b0;
        repeat (3) tick();
        check("rst_hold_req", 32'(rd_req), 32'd0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        exp_q.delete();
        last_m = N - 1;
        done_m = 0;
        check("pin_rr_after_rst", 32'(pick(24'h800001, last_m)), 32'd0);
        check("pin_rr_from0", 32'(pick(24'h800001, 0)), 32'd23);
        exp_q.push_back({1'b0, pick(24'h800001, last_m)});

        // Round robin between channels 0 and 23.
        for (int i = 0; i < 4; i++) begin
            serve_event(1, -1, -1, 1'b0, (i < 3) ? 24'h800001 : 24'h000020, 1'b0, 1'b1);
            ord[i] = last_served;
        end
        check("rr_order0", 32'(ord[0]), 32'd0);
        check("rr_order1", 32'(ord[1]), 32'd23);
        check("rr_order2", 32'(ord[2]), 32'd0);
        check("rr_order3", 32'(ord[3]), 32'd23);

        // Wrap: after channel 5, flags on 3 and 5 give channel 3.
        check("pin_wrap", 32'(pick(24'h000028, 5)), 32'd3);
        serve_event(1, -1, -1, 1'b0, 24'h000028, 1'b0, 1'b1);
        serve_event(1, -1, -1, 1'b0, 24'h000100, 1'b1, 1'b1);
        check("wrap_ch", 32'(last_served), 32'd3);

        // Continuation across three DPRAMs on channel 8.
        serve_event(3, -1, -1, 1'b0, 24'h000400, 1'b0, 1'b1);
        check("cont_ch", 32'(last_served), 32'd8);
`ifdef WVB_READER_EVT_CNT_EN
        check("cont_evt_cnt", evt_cnt, 32'd7);
`endif

        // Stray done in the request phase, enable dropped while the host waits.
        serve_event(1, -1, -1, 1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        check("stray_ch", 32'(last_served), 32'd10);
        repeat (8) begin
            tick();
            check("en_low_no_sel", 32'(rd_req), 32'd0);
        end
        en = 1'b1;
        check("pin_after_en", 32'(pick(24'hFFFFFF, last_m)), 32'd11);
        exp_q.push_back({1'b0, pick(24'hFFFFFF, last_m)});

        // Randomized events.
        for (int i = 0; i < 30; i++) begin
            nf = N'($urandom) | (N'(1) << $urandom_range(0, N - 1));
            nm = 1'($urandom_range(0, 1));
            if (i == 29) nf = '0;
            serve_event(0, -1, -1, 1'($urandom_range(0, 7) == 0), nf, nm, 1'b1);
        end
        repeat (5) begin
            tick();
            check("final_idle", 32'(rd_req), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
